// File: rtl/idli_sqi_ctrl.sv
// idli_sqi_ctrl: SQI serial-memory controller issuing read (0x03) / write (0x02) bursts of 16-bit words
//   i_clk, i_rst_n          clock, async active-low reset
//   i_req, i_wr, i_addr     request, direction and byte address (sampled in IDLE)
//   i_wdata, o_wr_rdy       write nibble and its consume strobe
//   o_rdata, o_rd_vld       read nibble and its valid strobe
//   o_busy                  controller outside IDLE
//   o_sqi_cs_n, o_sqi_mode, o_sqi_out, i_sqi_in   SQI pin interface
package idli_sqi_pkg;
  typedef enum logic {SQI_MODE_IN = 1'b0, SQI_MODE_OUT = 1'b1} sqi_mode_t;
endpackage

module idli_sqi_ctrl
  import idli_sqi_pkg::*;
#(
  parameter int unsigned RD_DUMMY = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req,
  input  logic        i_wr,
  input  logic [15:0] i_addr,
  input  logic [3:0]  i_wdata,
  output logic        o_wr_rdy,
  output logic        o_rd_vld,
  output logic [3:0]  o_rdata,
  output logic        o_busy,
  output logic        o_sqi_cs_n,
  output sqi_mode_t   o_sqi_mode,
  output logic [3:0]  o_sqi_out,
  input  logic [3:0]  i_sqi_in
);
  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_END} state_t;
  localparam logic [2:0] DUMMY_LAST = 3'(RD_DUMMY - 1);
  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [1:0]  nib_q, nib_d;
  logic        wr_q, wr_d;
  logic [15:0] addr_q, addr_d;
  logic [3:0]  cmd_nib, addr_nib;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      nib_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nib_q   <= nib_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nib_d   = nib_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    case (state_q)
      S_IDLE: if (i_req) begin
        state_d = S_CMD;
        cnt_d   = '0;
        nib_d   = '0;
        wr_d    = i_wr;
        addr_d  = i_addr;
      end
      S_CMD: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = S_ADDR;
          cnt_d   = '0;
        end
      end
      S_ADDR: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd5) begin
          state_d = (!wr_q && RD_DUMMY != 0) ? S_DUMMY : S_DATA;
          cnt_d   = '0;
        end
      end
      S_DUMMY: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == DUMMY_LAST) begin
          state_d = S_DATA;
          cnt_d   = '0;
        end
      end
      // The burst decision is made only on the last nibble of each word.
      S_DATA: begin
        nib_d = nib_q + 2'd1;
        if (nib_q == 2'd3 && !i_req) state_d = S_END;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_comb begin
    cmd_nib    = cnt_q[0] ? (wr_q ? 4'h2 : 4'h3) : 4'h0;
    // 24-bit address with a zero top byte, MSB nibble first
    addr_nib   = cnt_q == 3'd2 ? addr_q[15:12] :
                 cnt_q == 3'd3 ? addr_q[11:8]  :
                 cnt_q == 3'd4 ? addr_q[7:4]   :
                 cnt_q == 3'd5 ? addr_q[3:0]   : 4'h0;
    o_busy     = state_q != S_IDLE;
    o_sqi_cs_n = state_q == S_IDLE || state_q == S_END;
    o_wr_rdy   = state_q == S_DATA && wr_q;
    o_rd_vld   = state_q == S_DATA && !wr_q;
    o_rdata    = i_sqi_in;
    o_sqi_mode = (state_q == S_CMD || state_q == S_ADDR || o_wr_rdy) ? SQI_MODE_OUT : SQI_MODE_IN;
    o_sqi_out  = state_q == S_CMD  ? cmd_nib  :
                 state_q == S_ADDR ? addr_nib :
                 o_wr_rdy          ? i_wdata  : 4'h0;
  end
endmodule

// File: tb/tb_idli_sqi_ctrl.sv
// tb_idli_sqi_ctrl: scoreboard bench for idli_sqi_ctrl (RD_DUMMY=2 and RD_DUMMY=0 instances)
module tb_idli_sqi_ctrl;
  import idli_sqi_pkg::*;
  logic        i_clk = 1'b0, i_rst_n = 1'b0, i_req = 1'b0, i_wr = 1'b0;
  logic [15:0] i_addr = '0;
  logic [3:0]  i_wdata = '0, i_sqi_in = '0;
  logic        wr_rdy2, rd_vld2, busy2, cs2, wr_rdy0, rd_vld0, busy0, cs0;
  logic [3:0]  rdata2, out2, rdata0, out0;
  sqi_mode_t   mode2, mode0;
  logic        use0 = 1'b0;
  logic        ob_cs, ob_mode, ob_wr, ob_rd, ob_busy;
  logic [3:0]  ob_out, ob_rdata;
  int          checks = 0, failures = 0;
  always #5 i_clk = ~i_clk;
  idli_sqi_ctrl #(.RD_DUMMY(2)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_wr(i_wr), .i_addr(i_addr),
    .i_wdata(i_wdata), .o_wr_rdy(wr_rdy2), .o_rd_vld(rd_vld2), .o_rdata(rdata2),
    .o_busy(busy2), .o_sqi_cs_n(cs2), .o_sqi_mode(mode2), .o_sqi_out(out2), .i_sqi_in(i_sqi_in));
  idli_sqi_ctrl #(.RD_DUMMY(0)) dut0 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_wr(i_wr), .i_addr(i_addr),
    .i_wdata(i_wdata), .o_wr_rdy(wr_rdy0), .o_rd_vld(rd_vld0), .o_rdata(rdata0),
    .o_busy(busy0), .o_sqi_cs_n(cs0), .o_sqi_mode(mode0), .o_sqi_out(out0), .i_sqi_in(i_sqi_in));
  always_comb begin
    ob_cs    = use0 ? cs0 : cs2;
    ob_mode  = use0 ? mode0 : mode2;
    ob_wr    = use0 ? wr_rdy0 : wr_rdy2;
    ob_rd    = use0 ? rd_vld0 : rd_vld2;
    ob_busy  = use0 ? busy0 : busy2;
    ob_out   = use0 ? out0 : out2;
    ob_rdata = use0 ? rdata0 : rdata2;
  end
  typedef struct packed {logic req; logic wr; logic [15:0] addr; logic [3:0] wd;} stim_t;
  typedef struct packed {logic cs_n; logic mode; logic [3:0] sout; logic chk_out; logic wr_rdy; logic rd_vld; logic busy;} exp_t;
  stim_t stim_q[$];
  exp_t  exp_q[$];
  function automatic exp_t mk(input logic cs_n, input logic mode, input logic [3:0] sout,
                              input logic chk, input logic wr_rdy, input logic rd_vld, input logic busy);
    exp_t e;
    e = '{cs_n, mode, sout, chk, wr_rdy, rd_vld, busy};
    return e;
  endfunction
  // Outside IDLE the direction and address inputs are randomised so any leak is visible.
  task automatic push(input logic req, input logic [3:0] wd, input exp_t e);
    stim_t s;
    s = '{req, 1'($urandom), 16'($urandom), wd};
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask
  task automatic plan_txn(input logic wr, input logic [15:0] addr, input int dummy, input int words);
    stim_t s;
    logic [23:0] a24;
    logic [3:0] wd;
    logic req;
    s = '{1'b1, wr, addr, 4'($urandom)};
    stim_q.push_back(s);
    exp_q.push_back(mk(1, 0, 4'h0, 1, 0, 0, 0));
    for (int i = 0; i < 2; i++) push(1'($urandom), 4'($urandom), mk(0, 1, i == 0 ? 4'h0 : (wr ? 4'h2 : 4'h3), 1, 0, 0, 1));
    a24 = {8'h00, addr};
    for (int i = 0; i < 6; i++) push(1'($urandom), 4'($urandom), mk(0, 1, a24[23-4*i -: 4], 1, 0, 0, 1));
    for (int i = 0; i < dummy; i++) push(1'($urandom), 4'($urandom), mk(0, 0, 4'h0, 1, 0, 0, 1));
    for (int w = 0; w < words; w++)
      for (int k = 0; k < 4; k++) begin
        wd  = 4'hA + 4'(k);
        req = k == 3 ? 1'(w < words - 1) : 1'($urandom);
        if (wr) push(req, wd, mk(0, 1, wd, 1, 1, 0, 1));
        else    push(req, 4'($urandom), mk(0, 0, 4'h0, 0, 0, 1, 1));
      end
    push(1'b1, 4'($urandom), mk(1, 0, 4'h0, 0, 0, 0, 1));
    push(1'b0, 4'($urandom), mk(1, 0, 4'h0, 1, 0, 0, 0));
  endtask
  task automatic run(input string name, input int n);
    stim_t s;
    exp_t e;
    logic [8:0] act, req_v;
    int cyc = 0;
    while (exp_q.size() > 0 && (n < 0 || cyc < n)) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      @(posedge i_clk);
      #1;
      i_req = s.req; i_wr = s.wr; i_addr = s.addr; i_wdata = s.wd; i_sqi_in = 4'($urandom);
      @(negedge i_clk);
      act   = {ob_cs, ob_mode, e.chk_out ? ob_out : 4'h0, ob_wr, ob_rd, ob_busy};
      req_v = {e.cs_n, e.mode, e.chk_out ? e.sout : 4'h0, e.wr_rdy, e.rd_vld, e.busy};
      checks++;
      if (act !== req_v) begin
        failures++;
        $display("FAIL %s cycle %0d: {cs_n,mode,out,wr_rdy,rd_vld,busy} got %b want %b", name, cyc, act, req_v);
      end
      if (e.rd_vld) begin
        checks++;
        if (ob_rdata !== i_sqi_in) begin
          failures++;
          $display("FAIL %s rdata cycle %0d: got %h want %h", name, cyc, ob_rdata, i_sqi_in);
        end
      end
      cyc++;
    end
  endtask
  task automatic test_reset;
    i_rst_n = 1'b0;
    i_req = 1'b1;
    #3;
    checks++;
    if ({ob_cs, ob_mode, ob_out, ob_wr, ob_rd, ob_busy} !== 9'b1_0_0000_000) begin
      failures++;
      $display("FAIL reset_state: got %b want 100000000", {ob_cs, ob_mode, ob_out, ob_wr, ob_rd, ob_busy});
    end
    @(negedge i_clk);
    i_req = 1'b0;
    i_rst_n = 1'b1;
    push(1'b0, 4'h0, mk(1, 0, 4'h0, 1, 0, 0, 0));
    push(1'b0, 4'h0, mk(1, 0, 4'h0, 1, 0, 0, 0));
    run("idle_after_reset", -1);
  endtask
  task automatic test_read;
    plan_txn(1'b0, 16'h1234, 2, 1);
    run("read_1234", -1);
  endtask
  task automatic test_write;
    plan_txn(1'b1, 16'hFFFE, 0, 2);
    run("write_fffe", -1);
  endtask
  task automatic test_burst_req_ignored;
    plan_txn(1'b0, 16'hBEEF, 2, 3);
    plan_txn(1'b1, 16'h0F0F, 0, 3);
    run("burst_3w", -1);
  endtask
  task automatic test_back_to_back;
    plan_txn(1'b1, 16'h8001, 0, 1);
    plan_txn(1'b0, 16'h7FFE, 2, 2);
    plan_txn(1'b1, 16'h0000, 0, 1);
    run("back_to_back", -1);
  endtask
  task automatic test_reset_mid(input string name, input logic wr, input int skip);
    plan_txn(wr, 16'h5A3C, wr ? 0 : 2, 2);
    run(name, skip);
    #2;
    i_rst_n = 1'b0;
    #1;
    checks++;
    if ({ob_cs, ob_mode, ob_out, ob_wr, ob_rd, ob_busy} !== 9'b1_0_0000_000) begin
      failures++;
      $display("FAIL %s async_reset: got %b want 100000000", name, {ob_cs, ob_mode, ob_out, ob_wr, ob_rd, ob_busy});
    end
    stim_q.delete();
    exp_q.delete();
    i_req = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    plan_txn(1'b0, 16'hC0DE, 2, 1);
    run({name, "_after"}, -1);
  endtask
  task automatic test_rd_dummy0;
    @(negedge i_clk);
    i_rst_n = 1'b0;
    i_req = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    use0 = 1'b1;
    plan_txn(1'b0, 16'h9876, 0, 2);
    plan_txn(1'b1, 16'h4321, 0, 1);
    run("rd_dummy0", -1);
    use0 = 1'b0;
  endtask
  initial begin
    test_reset();
    test_read();
    test_write();
    test_burst_req_ignored();
    test_back_to_back();
    test_reset_mid("reset_in_addr", 1'b0, 5);
    test_reset_mid("reset_in_data", 1'b1, 11);
    test_rd_dummy0();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
